uncache_agent: RTL and testbench
================================

Name: uncache_agent

Overview:
- Sits directly downstream of the fixed-mapping address translator in the data-memory path.
- Consumes the physical address and cache-select flag.
- Requests with cache_sel=0 (kseg1, devices/MMIO) become single-beat transactions on an sram-like bus; the pipeline stalls until each transaction completes.
- Requests with cache_sel=1 are ignored; the dcache handles them.

Parameters:
- TIMEOUT, 0: watchdog limit in cycles for a bus transaction; 0 disables the watchdog.
- ERR_DATA, 32'hDEAD_BEEF: read data returned when a transaction times out.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- cpu_en  in  1  data access valid this cycle.
- cpu_wen  in  4  byte write enables; 0 means read.
- cpu_addr  in  32  physical address from translator.
- cpu_wdata  in  32  store data, lane-aligned.
- cpu_cache_sel  in  1  1 = cached (ignore), 0 = uncached (handle).
- stallreq  out  1  pipeline stall request, combinational.
- cpu_rdata  out  32  read result, valid in DONE and held until next accept.
- bus_req  out  1  transaction request.
- bus_wr  out  1  1 = write.
- bus_size  out  2  0 = byte, 1 = half, 2 = word.
- bus_addr  out  32  transaction address.
- bus_wstrb  out  4  write strobes.
- bus_wdata  out  32  write data.
- bus_addr_ok  in  1  request accepted by slave.
- bus_data_ok  in  1  response / write completion.
- bus_rdata  in  32  read data, valid with bus_data_ok.
- bus_err  out  1  one-cycle pulse on watchdog timeout.

Behaviour:
- Reset values:
  - state=IDLE.
  - bus_req=0, bus_wr=0, bus_size=0, bus_addr=0, bus_wstrb=0, bus_wdata=0.
  - cpu_rdata=0, bus_err=0.
  - Timeout counter=0.
- start = cpu_en & ~cpu_cache_sel & (state==IDLE).
- States:
  - IDLE: on start, latch request fields, go to REQ.
  - REQ: bus_req=1 with all bus fields stable. When bus_addr_ok=1:
    - If bus_data_ok=1 in the same cycle, go to DONE.
    - Otherwise go to RESP.
  - RESP: bus_req=0; wait for bus_data_ok, then go to DONE.
  - DONE: one cycle, unconditionally back to IDLE. Inputs are ignored this cycle; the presented request is the one just completed and must not be re-accepted.
- cpu_rdata latches bus_rdata on the bus_data_ok cycle, for reads only; write completion leaves it unchanged.
- stallreq = start | (state==REQ) | (state==RESP). It is low in DONE and IDLE without start. Cached accesses never stall here.
- Size/address encoding:
  - wen 0001/0010/0100/1000 -> size 0, addr unchanged.
  - wen 0011/1100 -> size 1, addr[0]=0.
  - wen 1111 -> size 2, addr[1:0]=0.
  - Read (wen 0000) -> size 2, addr[1:0]=0, wstrb=0; the load unit extracts bytes.
  - Any other wen pattern: treated as size 2, wstrb passed through.
- bus_wdata = cpu_wdata unchanged.
- Watchdog (TIMEOUT>0):
  - Counter clears on accept and increments each cycle in REQ/RESP.
  - On reaching TIMEOUT: force DONE, drop bus_req, set cpu_rdata=ERR_DATA (reads), pulse bus_err for one cycle.
  - A bus_data_ok arriving later is discarded: a stale-response flag is set and cleared by the next bus_data_ok.
- Reset mid-transaction: return to IDLE next edge, bus_req=0, no completion signalled. The slave shares the same reset.
- One outstanding transaction maximum; no reordering.

Optional Feature:
- Macro: UNCACHE_WBUF_EN.
- Defined:
  - One-entry posted write buffer.
  - An uncached write accepted in IDLE does not stall: stallreq=0 on the accept cycle.
  - The write proceeds through REQ/RESP in the background; on bus_data_ok it returns directly to IDLE, with no DONE.
  - Any uncached request arriving while the buffer is busy asserts stallreq until the buffer drains. It is then accepted in the following IDLE cycle, preserving order.
  - Reads are unchanged.
- Undefined: writes follow the full IDLE->REQ->RESP->DONE stall sequence, identical to reads.

Test Plan:
- Read 0x1FAF_F000 (cache_sel=0), slave addr_ok after 2 cycles, data_ok 3 cycles later with 0x1234_5678 -> stallreq high 6 cycles; cpu_rdata=0x1234_5678 in DONE; bus_size=2, bus_wr=0.
- Byte store wen=0100 addr 0x1FD0_03F9 data 0x00AB_0000 -> bus_size=0, bus_addr=0x1FD0_03F9, bus_wstrb=0100, bus_wr=1; cpu_rdata unchanged.
- cpu_en=1, cache_sel=1 -> bus_req stays 0, stallreq 0 all cycles.
- addr_ok and data_ok in the same cycle as the first REQ cycle -> REQ->DONE directly; stallreq high exactly 2 cycles.
- TIMEOUT=8, slave never responds -> bus_err pulses once; cpu_rdata=0xDEAD_BEEF; a late data_ok is ignored and the next read returns correct data.
- rst asserted during RESP -> next cycle state IDLE, bus_req=0, stallreq=0. With UNCACHE_WBUF_EN: write then immediate read -> write stallreq=0, read stalls until write data_ok, then a normal read sequence follows.

Source files
------------

// File: rtl/uncache_agent.sv
// uncache_agent: turns uncached (cache_sel=0) data accesses into single-beat sram-like bus transactions.
// Define UNCACHE_WBUF_EN to post uncached writes through a one-entry write buffer.
module uncache_agent #(
  parameter int          TIMEOUT  = 0,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_en,
  input  logic [3:0]  cpu_wen,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_cache_sel,
  output logic        stallreq,
  output logic [31:0] cpu_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        bus_err
);
`ifdef UNCACHE_WBUF_EN
  localparam bit WBUF = 1'b1;
`else
  localparam bit WBUF = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
  state_t state, state_n, fin_st;
  logic [31:0] cnt, addr;
  logic [1:0] size;
  logic want, start, busy, data_ok, fin, tmo, stale, posted;
  always_comb begin
    want = cpu_en & ~cpu_cache_sel;
    start = want & (state == IDLE);
    busy = (state == REQ) | (state == RESP);
    data_ok = bus_data_ok & ~stale;
    fin = (((state == REQ) & bus_addr_ok) | (state == RESP)) & data_ok;
    tmo = (TIMEOUT != 0) & busy & ~fin & (cnt == 32'(TIMEOUT - 1));
    size = (cpu_wen == 4'b0001 || cpu_wen == 4'b0010 || cpu_wen == 4'b0100 || cpu_wen == 4'b1000) ? 2'd0 :
           (cpu_wen == 4'b0011 || cpu_wen == 4'b1100) ? 2'd1 : 2'd2;
    addr = (size == 2'd0) ? cpu_addr : (size == 2'd1) ? {cpu_addr[31:1], 1'b0} : {cpu_addr[31:2], 2'b00};
    fin_st = posted ? IDLE : DONE;
    case (state)
      IDLE:    state_n = start ? REQ : IDLE;
      REQ:     state_n = (fin | tmo) ? fin_st : bus_addr_ok ? RESP : REQ;
      RESP:    state_n = (fin | tmo) ? fin_st : RESP;
      default: state_n = IDLE;
    endcase
  end
  // a posted write only stalls the pipeline when another uncached request queues behind it
  assign stallreq = (start & ~(WBUF & (|cpu_wen))) | (busy & (~posted | want));
  assign bus_req = (state == REQ);
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      stale     <= 1'b0;
      posted    <= 1'b0;
      bus_err   <= 1'b0;
      cpu_rdata <= '0;
      bus_wr    <= 1'b0;
      bus_size  <= '0;
      bus_addr  <= '0;
      bus_wstrb <= '0;
      bus_wdata <= '0;
    end else begin
      state   <= state_n;
      cnt     <= start ? '0 : busy ? cnt + 32'd1 : cnt;
      // an abandoned transaction the slave already accepted still owes one data_ok
      stale   <= (stale & ~bus_data_ok) | (tmo & ((state == RESP) | bus_addr_ok));
      bus_err <= tmo;
      if (fin & ~bus_wr) cpu_rdata <= bus_rdata;
      else if (tmo & ~bus_wr) cpu_rdata <= ERR_DATA;
      if (start) begin
        posted    <= WBUF & (|cpu_wen);
        bus_wr    <= |cpu_wen;
        bus_size  <= size;
        bus_addr  <= addr;
        bus_wstrb <= cpu_wen;
        bus_wdata <= cpu_wdata;
      end
    end
  end
endmodule

// File: tb/tb_uncache_agent.sv
// tb_uncache_agent: table vectors, watchdog/reset sequences and random transactions against a reference model.
module tb_uncache_agent;
`ifdef UNCACHE_WBUF_EN
  localparam bit WB = 1'b1;
`else
  localparam bit WB = 1'b0;
`endif
  logic clk = 1'b0, rst;
  logic cpu_en, cpu_cache_sel, stallreq, bus_req, bus_wr, bus_addr_ok, bus_data_ok, bus_err;
  logic [3:0] cpu_wen, bus_wstrb;
  logic [1:0] bus_size;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, bus_addr, bus_wdata, bus_rdata;
  uncache_agent #(.TIMEOUT(8), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .rst(rst), .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_cache_sel(cpu_cache_sel), .stallreq(stallreq), .cpu_rdata(cpu_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb),
    .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
    .bus_err(bus_err)
  );
  always #5 clk = ~clk;
  int nvec = 0, nmis = 0;
  int s_ad, s_dd, s_reqn, s_wt, s_acc;
  bit s_never, s_late;
  logic [31:0] s_rdata, cap_addr, cap_wdata;
  logic [1:0] cap_size;
  logic cap_wr;
  logic [3:0] cap_wstrb, s_hist;
  int got_stalls, got_errs;
  logic [31:0] got_rdata;
  bit got_done;
  logic [3:0] r_wen;
  logic [31:0] r_addr, r_wdata, r_rdata, e_addr, exp_rd;
  logic [1:0] e_size;
  int r_ad, r_dd;
  logic [3:0] pats [10] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF, 4'h6, 4'h9};
  typedef struct {
    logic [3:0] wen; logic [31:0] addr, wdata, rdata; int ad, dd;
    logic [1:0] esize; logic [31:0] eaddr; int estall; logic [31:0] erd;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic void ref_enc(input logic [3:0] wen, input logic [31:0] a, output logic [1:0] sz, output logic [31:0] ea);
    case (wen)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: begin sz = 2'd0; ea = a; end
      4'b0011, 4'b1100: begin sz = 2'd1; ea = a & ~32'd1; end
      default: begin sz = 2'd2; ea = a & ~32'd3; end
    endcase
  endfunction

  // slave: accepts after s_ad waiting REQ cycles, answers s_dd cycles after accept
  task automatic slave_step();
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    bus_rdata = $urandom;
    if (bus_req) begin
      if (s_reqn == s_ad) begin
        bus_addr_ok = 1'b1;
        cap_wr = bus_wr; cap_size = bus_size; cap_addr = bus_addr; cap_wstrb = bus_wstrb; cap_wdata = bus_wdata;
        s_hist = {s_hist[2:0], bus_wr};
        s_acc++;
        s_wt = s_dd;
        s_reqn = 0;
      end else s_reqn++;
    end else if (s_late && s_wt > 0) begin
      bus_data_ok = 1'b1;
      bus_rdata = 32'hBAD0_BAD0;
      s_late = 1'b0;
      return;
    end else if (s_wt > 0) s_wt--;
    if (s_wt == 0 && !s_never) begin
      bus_data_ok = 1'b1;
      bus_rdata = s_rdata;
      s_wt = -1;
    end
  endtask

  task automatic txn(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] rdata, input int ad, input int dd, input bit never);
    s_ad = ad; s_dd = dd; s_never = never; s_rdata = rdata; s_reqn = 0; s_wt = -1;
    cpu_en = 1'b1; cpu_cache_sel = 1'b0; cpu_wen = wen; cpu_addr = addr; cpu_wdata = wdata;
    got_stalls = 0; got_errs = 0; got_done = 1'b0; got_rdata = 'x;
    for (int k = 0; k < 40 && !got_done; k++) begin
      slave_step();
      @(negedge clk);
      if (bus_err) got_errs++;
      if (stallreq) got_stalls++;
      else begin got_done = 1'b1; got_rdata = cpu_rdata; end
      @(posedge clk); #1;
    end
    cpu_en = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0; s_late = 1'b0;
    chk("txn_done", 32'(got_done), 32'd1);
  endtask

  initial begin
    rst = 1'b1; cpu_en = 1'b0; cpu_cache_sel = 1'b0; cpu_wen = '0; cpu_addr = '0; cpu_wdata = '0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0; s_late = 1'b0; s_hist = '0; s_acc = 0;
    tbl[0] = '{4'b0000, 32'h1FAF_F000, 32'h0,         32'h1234_5678, 1, 3, 2'd2, 32'h1FAF_F000, 6, 32'h1234_5678};
    tbl[1] = '{4'b0100, 32'h1FD0_03F9, 32'h00AB_0000, 32'h5555_5555, 0, 1, 2'd0, 32'h1FD0_03F9, 3, 32'h1234_5678};
    tbl[2] = '{4'b0000, 32'hBFC0_0007, 32'h0,         32'hCAFE_F00D, 0, 0, 2'd2, 32'hBFC0_0004, 2, 32'hCAFE_F00D};
    tbl[3] = '{4'b1100, 32'h1000_0003, 32'hBEEF_0000, 32'h1111_1111, 2, 0, 2'd1, 32'h1000_0002, 4, 32'hCAFE_F00D};
    tbl[4] = '{4'b1111, 32'h1000_0017, 32'h0102_0304, 32'h2222_2222, 0, 2, 2'd2, 32'h1000_0014, 4, 32'hCAFE_F00D};
    tbl[5] = '{4'b0110, 32'h1000_0005, 32'h00FF_FF00, 32'h3333_3333, 1, 1, 2'd2, 32'h1000_0004, 4, 32'hCAFE_F00D};
    tbl[6] = '{4'b0011, 32'h2000_0001, 32'h0000_ABCD, 32'h4444_4444, 0, 0, 2'd1, 32'h2000_0000, 2, 32'hCAFE_F00D};
    tbl[7] = '{4'b0000, 32'h0000_0002, 32'h0,         32'h0BAD_F00D, 3, 3, 2'd2, 32'h0000_0000, 8, 32'h0BAD_F00D};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_bus_wr", 32'(bus_wr), 32'd0);
    chk("rst_bus_size", 32'(bus_size), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wstrb", 32'(bus_wstrb), 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_stallreq", 32'(stallreq), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    // cached accesses never reach the bus or stall
    cpu_en = 1'b1; cpu_cache_sel = 1'b1; cpu_addr = 32'h8000_0000;
    for (int k = 0; k < 4; k++) begin
      cpu_wen = (k % 2 == 0) ? 4'h0 : 4'hF;
      @(negedge clk);
      chk("cached_quiet", {30'd0, bus_req, stallreq}, 32'd0);
      @(posedge clk); #1;
    end
    cpu_en = 1'b0; cpu_cache_sel = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (WB && tbl[i].wen != 4'h0) continue;
      txn(tbl[i].wen, tbl[i].addr, tbl[i].wdata, tbl[i].rdata, tbl[i].ad, tbl[i].dd, 1'b0);
      chk("tbl_stalls", got_stalls, tbl[i].estall);
      chk("tbl_size", 32'(cap_size), 32'(tbl[i].esize));
      chk("tbl_addr", cap_addr, tbl[i].eaddr);
      chk("tbl_wr", 32'(cap_wr), 32'(tbl[i].wen != 4'h0));
      chk("tbl_wstrb", 32'(cap_wstrb), 32'(tbl[i].wen));
      chk("tbl_wdata", cap_wdata, tbl[i].wdata);
      chk("tbl_rdata", got_rdata, tbl[i].erd);
      chk("tbl_no_err", got_errs, 0);
      chk("tbl_no_reaccept", 32'(bus_req), 32'd0);
    end
    // watchdog: slave accepts but never answers
    txn(4'h0, 32'h1FC0_0100, 32'h0, 32'h0, 0, 0, 1'b1);
    chk("tmo_stalls", got_stalls, 9);
    chk("tmo_err_pulses", got_errs, 1);
    chk("tmo_rdata", got_rdata, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("tmo_err_drop", 32'(bus_err), 32'd0);
    @(posedge clk); #1;
    // the late data_ok lands during the next read and must be discarded
    s_late = 1'b1;
    txn(4'h0, 32'h1FC0_0200, 32'h0, 32'h5A5A_1234, 0, 3, 1'b0);
    chk("stale_stalls", got_stalls, 6);
    chk("stale_rdata", got_rdata, 32'h5A5A_1234);
    // reset while waiting in RESP
    s_ad = 0; s_dd = 10; s_never = 1'b0; s_reqn = 0; s_wt = -1; s_rdata = 32'h0;
    cpu_en = 1'b1; cpu_cache_sel = 1'b0; cpu_wen = 4'h0; cpu_addr = 32'h1FC0_0000;
    for (int k = 0; k < 2; k++) begin
      slave_step();
      @(negedge clk);
      @(posedge clk); #1;
    end
    slave_step();
    rst = 1'b1; cpu_en = 1'b0;
    @(negedge clk);
    chk("resp_stall", 32'(stallreq), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0; s_wt = -1;
    @(negedge clk);
    chk("rstmid_bus_req", 32'(bus_req), 32'd0);
    chk("rstmid_stallreq", 32'(stallreq), 32'd0);
    chk("rstmid_rdata", cpu_rdata, 32'd0);
    chk("rstmid_err", 32'(bus_err), 32'd0);
    @(posedge clk); #1;
    txn(4'h0, 32'h1FC0_0004, 32'h0, 32'h600D_CAFE, 0, 0, 1'b0);
    chk("rstmid_next_stalls", got_stalls, 2);
    chk("rstmid_next_rdata", got_rdata, 32'h600D_CAFE);
`ifdef UNCACHE_WBUF_EN
    // posted write followed immediately by a read
    s_ad = 0; s_dd = 2; s_never = 1'b0; s_reqn = 0; s_wt = -1; s_acc = 0; s_hist = '0; s_rdata = 32'h7766_5544;
    cpu_en = 1'b1; cpu_cache_sel = 1'b0; cpu_wen = 4'hF; cpu_addr = 32'h1FD0_0010; cpu_wdata = 32'h1111_2222;
    got_stalls = 0; got_done = 1'b0;
    for (int k = 0; k < 30 && !got_done; k++) begin
      slave_step();
      @(negedge clk);
      if (k == 0) chk("wbuf_post_nostall", 32'(stallreq), 32'd0);
      else if (stallreq) got_stalls++;
      else begin got_done = 1'b1; got_rdata = cpu_rdata; end
      @(posedge clk); #1;
      if (k == 0) begin cpu_wen = 4'h0; cpu_addr = 32'h1FD0_0020; end
    end
    cpu_en = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    chk("wbuf_done", 32'(got_done), 32'd1);
    chk("wbuf_read_stalls", got_stalls, 7);
    chk("wbuf_accepts", s_acc, 2);
    chk("wbuf_order", 32'(s_hist[1:0]), 32'd2);
    chk("wbuf_rdata", got_rdata, 32'h7766_5544);
`endif
    exp_rd = 'x;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(3) == 0) begin
        cpu_en = 1'b1; cpu_cache_sel = 1'b1; cpu_wen = pats[$urandom_range(9)]; cpu_addr = $urandom;
        @(negedge clk);
        chk("rnd_cached", {30'd0, bus_req, stallreq}, 32'd0);
        @(posedge clk); #1;
        cpu_en = 1'b0; cpu_cache_sel = 1'b0;
      end
      r_wen = (i == 0 || WB) ? 4'h0 : pats[$urandom_range(9)];
      r_addr = $urandom; r_wdata = $urandom; r_rdata = $urandom;
      r_ad = $urandom_range(3); r_dd = $urandom_range(3);
      ref_enc(r_wen, r_addr, e_size, e_addr);
      if (r_wen == 4'h0) exp_rd = r_rdata;
      txn(r_wen, r_addr, r_wdata, r_rdata, r_ad, r_dd, 1'b0);
      chk("rnd_stalls", got_stalls, r_ad + r_dd + 2);
      chk("rnd_size", 32'(cap_size), 32'(e_size));
      chk("rnd_addr", cap_addr, e_addr);
      chk("rnd_wr", 32'(cap_wr), 32'(r_wen != 4'h0));
      chk("rnd_wstrb", 32'(cap_wstrb), 32'(r_wen));
      chk("rnd_wdata", cap_wdata, r_wdata);
      chk("rnd_rdata", got_rdata, exp_rd);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
